// File: rtl/blink_sched_pkg.sv
// Shared types and default sizing for the blink scheduler.
package blink_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/blink_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blink_sched.sv
// Shared blink-output scheduler: round-robin grants bursts of on/off blinks.
// Optional macro BLINK_SCHED_ABORT_EN: dropping the granted request aborts the burst.
//
//   state | meaning
//   IDLE  | no burst, waiting for any request
//   ON    | blink output high for one half period
//   OFF   | blink output low for one half period; zero-length bursts pass here once
module blink_sched
    import blink_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0]         half_period_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     blinky_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   phase_cnt;
    logic [CNT_W-1:0]   hp_m1;
    logic [LEN_W-1:0]   blink_cnt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [LEN_W-1:0]   len_sel;
    logic [CNT_W-1:0]   hp_in_m1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req_i),
        .ptr (last_grant),
        .gnt (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = IDX_W'(i);
        end
    end

    assign len_sel = len_i[arb_idx*LEN_W +: LEN_W];
    // Phase counter counts down to zero, so load half_period-1; zero behaves as one.
    assign hp_in_m1 = (half_period_i == '0) ? '0 : half_period_i - CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            phase_cnt  <= '0;
            hp_m1      <= '0;
            blink_cnt  <= '0;
            gnt_o      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            blinky_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
`ifdef BLINK_SCHED_ABORT_EN
            if (state != IDLE && !req_i[last_grant]) begin
                state     <= IDLE;
                phase_cnt <= '0;
                blink_cnt <= '0;
                gnt_o     <= '0;
                busy_o    <= 1'b0;
                blinky_o  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (|req_i) begin
                            gnt_o      <= arb_gnt;
                            busy_o     <= 1'b1;
                            last_grant <= arb_idx;
                            hp_m1      <= hp_in_m1;
                            // A zero-length burst spends a single cycle in OFF, then completes.
                            if (len_sel == '0) begin
                                state     <= OFF;
                                blinky_o  <= 1'b0;
                                phase_cnt <= '0;
                                blink_cnt <= '0;
                            end else begin
                                state     <= ON;
                                blinky_o  <= 1'b1;
                                phase_cnt <= hp_in_m1;
                                blink_cnt <= len_sel;
                            end
                        end
                    end
                    ON: begin
                        if (phase_cnt == '0) begin
                            state     <= OFF;
                            blinky_o  <= 1'b0;
                            phase_cnt <= hp_m1;
                            blink_cnt <= blink_cnt - LEN_W'(1);
                        end else begin
                            phase_cnt <= phase_cnt - CNT_W'(1);
                        end
                    end
                    OFF: begin
                        if (phase_cnt == '0) begin
                            if (blink_cnt != '0) begin
                                state     <= ON;
                                blinky_o  <= 1'b1;
                                phase_cnt <= hp_m1;
                            end else begin
                                state  <= IDLE;
                                done_o <= 1'b1;
                                gnt_o  <= '0;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            phase_cnt <= phase_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        gnt_o    <= '0;
                        busy_o   <= 1'b0;
                        blinky_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched; expectations follow the abort macro when defined.
module tb_blink_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [15:0] hp;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        blinky;

    int checks = 0;
    int errors = 0;

    blink_sched #(.NUM_REQ(4), .CNT_W(16), .LEN_W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .len_i         (len),
        .half_period_i (hp),
        .gnt_o         (gnt),
        .busy_o        (busy),
        .done_o        (done),
        .blinky_o      (blinky)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; len = '0; hp = '0;
        #2;
        checks++;
        if ({gnt, busy, done, blinky} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b blinky=%b, want all 0", gnt, busy, done, blinky);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({gnt, busy, done, blinky} !== 7'b0) begin
            errors++;
            $display("FAIL reset_idle: got gnt=%b busy=%b done=%b blinky=%b, want all 0", gnt, busy, done, blinky);
        end
    endtask

    // len=3, hp=2 on requester 0; inputs altered mid-burst must not matter.
    task automatic test_single();
        logic [11:0] pat;
        pat = 12'b110011001100;
        req = 4'b0001; len = 16'h0003; hp = 16'd2;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 1) begin len = 16'h0009; hp = 16'd7; end
            checks++;
            if (blinky !== pat[11-c] || gnt !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL single_c%0d: got blinky=%b gnt=%b busy=%b done=%b, want blinky=%b gnt=0001 busy=1 done=0",
                         c, blinky, gnt, busy, done, pat[11-c]);
            end
        end
        step();
        req = 4'b0000;
        checks++;
        if (done !== 1'b1 || gnt !== 4'b0 || busy !== 1'b0 || blinky !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b gnt=%b busy=%b blinky=%b, want done=1 gnt=0000 busy=0 blinky=0", done, gnt, busy, blinky);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111; len = 16'h1111; hp = 16'd1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            step();
            checks++;
            if (gnt !== exp_g || blinky !== 1'b1) begin
                errors++;
                $display("FAIL rr_on_%0d: got gnt=%b blinky=%b, want gnt=%b blinky=1", k, gnt, blinky, exp_g);
            end
            step();
            checks++;
            if (gnt !== exp_g || blinky !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rr_off_%0d: got gnt=%b blinky=%b done=%b, want gnt=%b blinky=0 done=0", k, gnt, blinky, done, exp_g);
            end
            step();
            if (k == 4) req = 4'b0000;
            checks++;
            if (gnt !== 4'b0 || done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_done_%0d: got gnt=%b done=%b busy=%b, want gnt=0000 done=1 busy=0", k, gnt, done, busy);
            end
        end
    endtask

    task automatic test_hp_zero();
        logic [3:0] pat;
        pat = 4'b1010;
        req = 4'b0001; len = 16'h0002; hp = 16'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (blinky !== pat[3-c] || gnt !== 4'b0001 || done !== 1'b0) begin
                errors++;
                $display("FAIL hp0_c%0d: got blinky=%b gnt=%b done=%b, want blinky=%b gnt=0001 done=0", c, blinky, gnt, done, pat[3-c]);
            end
        end
        step();
        req = 4'b0000;
        checks++;
        if (done !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL hp0_done: got done=%b gnt=%b, want done=1 gnt=0000", done, gnt);
        end
    endtask

    task automatic test_len_zero();
        req = 4'b1100; len = 16'h1000; hp = 16'd1;
        step();
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || blinky !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL len0_grant: got gnt=%b busy=%b blinky=%b done=%b, want 0100 1 0 0", gnt, busy, blinky, done);
        end
        step();
        checks++;
        if (gnt !== 4'b0 || done !== 1'b1 || blinky !== 1'b0) begin
            errors++;
            $display("FAIL len0_done: got gnt=%b done=%b blinky=%b, want 0000 1 0", gnt, done, blinky);
        end
        step();
        checks++;
        if (gnt !== 4'b1000 || blinky !== 1'b1) begin
            errors++;
            $display("FAIL len0_next: got gnt=%b blinky=%b, want 1000 1", gnt, blinky);
        end
        step();
        step();
        req = 4'b0000;
        checks++;
        if (done !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL len0_next_done: got done=%b gnt=%b, want 1 0000", done, gnt);
        end
        step();
    endtask

    // Requester 0 granted first (last_grant=3 after len-zero test); reset on cycle 3.
    task automatic test_reset_mid();
        int done_seen;
        req = 4'b0011; len = 16'h0014; hp = 16'd1;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (gnt !== 4'b0001 || blinky !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got gnt=%b blinky=%b, want 0001 1", gnt, blinky);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, busy, done, blinky} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_async: got gnt=%b busy=%b done=%b blinky=%b, want all 0", gnt, busy, done, blinky);
        end
        done_seen = 0;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) done_seen++;
        end
        rst = 1'b0;
        step();
        if (done) done_seen++;
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rstmid_nodone: got %0d done pulses, want 0", done_seen);
        end
        req = 4'b0011; len = 16'h0011;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_regrant: got gnt=%b, want 0001", gnt);
        end
        do_reset();
    endtask

    task automatic test_req_drop();
        req = 4'b0001; len = 16'h0002; hp = 16'd1;
        step();
        step();
        checks++;
        if (gnt !== 4'b0001 || blinky !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_off: got gnt=%b blinky=%b busy=%b, want 0001 0 1", gnt, blinky, busy);
        end
        req = 4'b0000;
        step();
`ifdef BLINK_SCHED_ABORT_EN
        checks++;
        if ({gnt, busy, done, blinky} !== 7'b0) begin
            errors++;
            $display("FAIL drop_abort: got gnt=%b busy=%b done=%b blinky=%b, want all 0", gnt, busy, done, blinky);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_abort_nodone: got done=%b busy=%b, want 0 0", done, busy);
        end
`else
        checks++;
        if (gnt !== 4'b0001 || blinky !== 1'b1) begin
            errors++;
            $display("FAIL drop_ignored: got gnt=%b blinky=%b, want 0001 1", gnt, blinky);
        end
        step();
        step();
        checks++;
        if (done !== 1'b1 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL drop_done: got done=%b gnt=%b, want 1 0000", done, gnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hp_zero();
        test_len_zero();
        test_reset_mid();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_sched.md
BLINK_SCHED -- requirements
Module: blink_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the blink output.
REQ-002 SHALL have parameter CNT_W, default 16: half-period counter width.
REQ-003 SHALL have parameter LEN_W, default 4: burst-length width.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_i, input, NUM_REQ: per-requester burst request, level.
REQ-007 SHALL have port len_i, input, NUM_REQ x LEN_W: per-requester blink count.
REQ-008 SHALL have port half_period_i, input, CNT_W: cycles per on/off phase.
REQ-009 SHALL have port gnt_o, output, NUM_REQ: one-hot grant, held for the whole burst.
REQ-010 SHALL have port busy_o, output, 1: burst in progress.
REQ-011 SHALL have port done_o, output, 1: single-cycle burst-complete pulse.
REQ-012 SHALL have port blinky_o, output, 1: shared blink output, registered.

Function
REQ-013 SHALL implement the FSM states IDLE, ON, OFF.
REQ-014 IDLE with any req_i bit set SHALL, at the next edge, grant exactly one requester, latch its len_i slice and half_period_i, and enter ON with blinky_o=1.
REQ-015 Arbitration SHALL be round-robin: search starts at index last_grant+1 and wraps modulo NUM_REQ; last_grant updates on every grant.
REQ-016 ON and OFF SHALL each last exactly max(half_period,1) cycles; a latched half_period of 0 SHALL behave as 1.
REQ-017 ON SHALL always go to OFF (blinky_o=0); OFF SHALL go to ON if blinks remain, else to IDLE.
REQ-018 A burst of length L SHALL produce exactly L high pulses on blinky_o.
REQ-019 On the OFF-to-IDLE edge, done_o SHALL be 1 for one cycle, and gnt_o and busy_o SHALL clear.
REQ-020 A latched length of 0 SHALL grant for one cycle, produce no blink, pulse done_o on the next edge, and advance the round-robin pointer.
REQ-021 busy_o SHALL equal (state != IDLE); gnt_o SHALL be nonzero iff busy_o is 1.
REQ-022 After done_o, at least one IDLE cycle SHALL elapse before the next grant.
REQ-023 Changes to len_i or half_period_i during a burst SHALL NOT affect it.
REQ-024 Without the abort feature, a granted requester deasserting req_i mid-burst SHALL be ignored, and the burst SHALL complete.

Reset
REQ-025 rst_i high SHALL immediately force IDLE, blinky_o=0, gnt_o=0, busy_o=0, done_o=0, counters=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-026 Reset asserted mid-burst SHALL abort the burst with no done_o pulse.

Configuration
REQ-027 Macro BLINK_SCHED_ABORT_EN, when defined: deassert of the granted req_i bit in ON or OFF SHALL force IDLE at the next edge, with blinky_o=0 and gnt_o cleared, and done_o SHALL NOT pulse.
REQ-028 When BLINK_SCHED_ABORT_EN is undefined, REQ-024 SHALL apply, and no abort logic SHALL be present.

Structure
REQ-029 Package blink_sched_pkg SHALL hold the state enum type and the default constants for NUM_REQ, CNT_W and LEN_W.
REQ-030 Round-robin selection SHALL live in a sub-module rr_arbiter: request vector and pointer in, one-hot grant out, combinational.
REQ-031 The FSM, phase counter and blink counter SHALL reside in blink_sched.

Verification
REQ-032 Reset, then req_i=0001, len=3, half_period=2 -> blinky_o pattern 1100 1100 1100, gnt_o=0001 for 12 cycles, done_o pulses once.
REQ-033 req_i=1111 held, all len=1, half_period=1 -> grants in order 0001,0010,0100,1000,0001, each followed by done_o.
REQ-034 half_period=0, len=2 -> blinky_o 1010 (as half_period=1), done_o once.
REQ-035 len=0 on requester 2 with requester 3 also requesting -> gnt_o=0100 for one cycle, no blink, done_o, then gnt_o=1000.
REQ-036 rst_i pulsed on cycle 3 of a len=4 burst -> all outputs 0 at once, no done_o, next grant goes to requester 0.
REQ-037 With BLINK_SCHED_ABORT_EN, the granted req drops in OFF -> IDLE next cycle, no done_o; without the macro -> the burst completes to done_o.
